// File: rtl/bounded_enum_seq_pkg.sv
// Shared types for the bounded enumerator: FSM state encoding and its width.
// Optional index output is enabled by defining BOUNDED_ENUM_INDEX_EN.
package bounded_enum_pkg;
    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/bounded_enum_seq_if.sv
// Element handshake bundle: start/bounds from the producer, req from the consumer, ack/eol/value back.
// Handshake: req is a level; every cycle req is sampled high (and start low, state armed) yields ack=1 one cycle later.
interface bounded_enum_seq_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] min;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] max;
    logic             descend;
    logic             req;
    logic             ack;
    logic             eol;
    logic [WIDTH-1:0] value;
    logic             busy;
`ifdef BOUNDED_ENUM_INDEX_EN
    logic [WIDTH-1:0] index;

    modport master (output start, min, step, max, descend, req,
                    input  ack, eol, value, busy, index);
    modport slave  (input  start, min, step, max, descend, req,
                    output ack, eol, value, busy, index);
`else
    modport master (output start, min, step, max, descend, req,
                    input  ack, eol, value, busy);
    modport slave  (input  start, min, step, max, descend, req,
                    output ack, eol, value, busy);
`endif
endinterface

// File: rtl/bounded_enum_seq_step.sv
// Combinational successor of v and whether v is the final element (successor out of bounds).
// Arithmetic is done one bit wider so a carry/borrow ends the sequence instead of wrapping.
module bounded_enum_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max,
    input  logic             descend,
    output logic [WIDTH-1:0] next,
    output logic             last
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           zero_step;

    always_comb begin
        sum       = {1'b0, v} + {1'b0, step};
        diff      = {1'b0, v} - {1'b0, step};
        zero_step = (step == '0);
        if (descend) begin
            next = diff[WIDTH-1:0];
            last = diff[WIDTH] || (diff[WIDTH-1:0] < max) || zero_step;
        end else begin
            next = sum[WIDTH-1:0];
            last = sum[WIDTH] || (sum[WIDTH-1:0] > max) || zero_step;
        end
    end
endmodule

// File: rtl/bounded_enum_seq.sv
// Bounded arithmetic enumerator: delivers min, min+/-step, ... up to max, one element per req.
// Define BOUNDED_ENUM_INDEX_EN to add a saturating element index output.
module bounded_enum_seq
    import bounded_enum_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int WRAP  = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    bounded_enum_seq_if.slave        bus,
    output state_t                   fsm_state
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] min_q, step_q, max_q, nxt_q, value_q;
    logic             desc_q, ack_q, eol_q, pend_q;
    logic [WIDTH-1:0] v_sel, next_v;
    logic             last_v, deliver, empty;

    // nxt_q holds the element the next req will deliver; pend_q marks it as a wrap restart.
    assign v_sel = (state_q == FIRST) ? min_q : nxt_q;
    assign empty = bus.descend ? (bus.min < bus.max) : (bus.min > bus.max);

    bounded_enum_step #(.WIDTH(WIDTH)) u_step (
        .v       (v_sel),
        .step    (step_q),
        .max     (max_q),
        .descend (desc_q),
        .next    (next_v),
        .last    (last_v)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        deliver = 1'b0;
        if (bus.start) begin
            state_d = empty ? DONE : FIRST;
        end else if (bus.req) begin
            unique case (state_q)
                FIRST: begin
                    deliver = 1'b1;
                    state_d = last_v ? DONE : RUN;
                end
                RUN: begin
                    deliver = 1'b1;
                    if (last_v && WRAP == 0) state_d = DONE;
                end
                DONE: begin
                    if (WRAP != 0) begin
                        deliver = 1'b1;
                        state_d = last_v ? DONE : RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q   <= '0;
            step_q  <= '0;
            max_q   <= '0;
            desc_q  <= 1'b0;
            nxt_q   <= '0;
            value_q <= '0;
            ack_q   <= 1'b0;
            eol_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (bus.start) begin
            min_q   <= bus.min;
            step_q  <= bus.step;
            max_q   <= bus.max;
            desc_q  <= bus.descend;
            nxt_q   <= bus.min;
            value_q <= bus.min;
            ack_q   <= 1'b0;
            eol_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else if (bus.req && state_q != IDLE) begin
            ack_q <= 1'b1;
            if (deliver) begin
                value_q <= v_sel;
                eol_q   <= last_v;
                nxt_q   <= last_v ? min_q : next_v;
                pend_q  <= last_v;
            end else begin
                eol_q <= 1'b1;
            end
        end else begin
            ack_q <= 1'b0;
            eol_q <= 1'b0;
        end
    end

`ifdef BOUNDED_ENUM_INDEX_EN
    logic [WIDTH-1:0] index_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)           index_q <= '0;
        else if (bus.start)     index_q <= '0;
        else if (deliver) begin
            if (pend_q)         index_q <= '0;
            else if (!(&index_q)) index_q <= index_q + 1'b1;
        end
    end

    assign bus.index = index_q;
`endif

    assign bus.ack   = ack_q;
    assign bus.eol   = eol_q;
    assign bus.value = value_q;
    assign bus.busy  = (state_q == FIRST) || (state_q == RUN);
    assign fsm_state = state_q;
endmodule

// File: tb/tb_bounded_enum_seq.sv
// Directed bench for bounded_enum_seq: one WRAP=0 and one WRAP=1 instance, expected queue per step.
module tb_bounded_enum_seq;
    import bounded_enum_pkg::*;

    logic   clock = 1'b0;
    logic   reset_n = 1'b0;
    state_t st0, st1;
    int     checks = 0;
    int     errors = 0;

    // Packed expectation: {value_check, ack, eol, value}
    logic [10:0] exp_q[$];

    bounded_enum_seq_if #(.WIDTH(8)) bus0();
    bounded_enum_seq_if #(.WIDTH(8)) bus1();

    bounded_enum_seq #(.WIDTH(8), .WRAP(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .bus(bus0), .fsm_state(st0));
    bounded_enum_seq #(.WIDTH(8), .WRAP(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .bus(bus1), .fsm_state(st1));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus0.start = 0; bus0.req = 0; bus0.min = 0; bus0.step = 0; bus0.max = 0; bus0.descend = 0;
        bus1.start = 0; bus1.req = 0; bus1.min = 0; bus1.step = 0; bus1.max = 0; bus1.descend = 0;
    endtask

    // Drive one cycle on instance d, push expectation, compare after the edge.
    task automatic cyc(input string tag, input int d, input bit st, input bit rq,
                       input logic [7:0] mn, input logic [7:0] sp, input logic [7:0] mx, input bit ds,
                       input bit vchk, input bit e_ack, input bit e_eol, input logic [7:0] e_val);
        logic [10:0] e;
        logic [10:0] g;
        idle_inputs();
        if (d == 0) begin
            bus0.start = st; bus0.req = rq; bus0.min = mn; bus0.step = sp; bus0.max = mx; bus0.descend = ds;
        end else begin
            bus1.start = st; bus1.req = rq; bus1.min = mn; bus1.step = sp; bus1.max = mx; bus1.descend = ds;
        end
        exp_q.push_back({vchk, e_ack, e_eol, e_val});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        if (d == 0) g = {e[10], bus0.ack, bus0.eol, bus0.value};
        else        g = {e[10], bus1.ack, bus1.eol, bus1.value};
        if (!e[10]) begin
            g[7:0] = 8'h00;
            e[7:0] = 8'h00;
        end
        check(tag, 32'(g), 32'(e));
        idle_inputs();
    endtask

    task automatic rq(input string tag, input int d, input bit r,
                      input bit e_ack, input bit e_eol, input logic [7:0] e_val);
        cyc(tag, d, 1'b0, r, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, e_ack, e_eol, e_val);
    endtask

    initial begin
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        check("rst_ack",   32'(bus0.ack),   32'd0);
        check("rst_eol",   32'(bus0.eol),   32'd0);
        check("rst_value", 32'(bus0.value), 32'd0);
        check("rst_busy",  32'(bus0.busy),  32'd0);
        check("rst_state", 32'(st0),        32'(IDLE));
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Idle: req ignored before any start
        rq("idle_req", 0, 1, 0, 0, 8'd0);

        // Ascending 3,5,7,9
        cyc("asc_start", 0, 1, 0, 8'd3, 8'd2, 8'd9, 0, 0, 0, 0, 8'd0);
        check("asc_busy_first", 32'(bus0.busy), 32'd1);
`ifdef BOUNDED_ENUM_INDEX_EN
        check("idx_start", 32'(bus0.index), 32'd0);
`endif
        rq("asc_3", 0, 1, 1, 0, 8'd3);
`ifdef BOUNDED_ENUM_INDEX_EN
        check("idx_1", 32'(bus0.index), 32'd1);
`endif
        rq("asc_5", 0, 1, 1, 0, 8'd5);
        rq("asc_7", 0, 1, 1, 0, 8'd7);
        rq("asc_9", 0, 1, 1, 1, 8'd9);
`ifdef BOUNDED_ENUM_INDEX_EN
        check("idx_4", 32'(bus0.index), 32'd4);
`endif
        rq("asc_rep1", 0, 1, 1, 1, 8'd9);
        rq("asc_rep2", 0, 1, 1, 1, 8'd9);
        check("asc_busy_done", 32'(bus0.busy), 32'd0);
`ifdef BOUNDED_ENUM_INDEX_EN
        check("idx_rep", 32'(bus0.index), 32'd4);
`endif
        rq("asc_noreq", 0, 0, 0, 0, 8'd9);

        // Overflow-safe: 250,254 then stop
        cyc("ovf_start", 0, 1, 0, 8'd250, 8'd4, 8'd255, 0, 0, 0, 0, 8'd0);
        rq("ovf_250", 0, 1, 1, 0, 8'd250);
        rq("ovf_254", 0, 1, 1, 1, 8'd254);
        rq("ovf_rep", 0, 1, 1, 1, 8'd254);

        // Descending 10,7,4
        cyc("dsc_start", 0, 1, 0, 8'd10, 8'd3, 8'd2, 1, 0, 0, 0, 8'd0);
        rq("dsc_10", 0, 1, 1, 0, 8'd10);
        rq("dsc_7",  0, 1, 1, 0, 8'd7);
        rq("dsc_4",  0, 1, 1, 1, 8'd4);
        rq("dsc_rep", 0, 1, 1, 1, 8'd4);

        // Descending with borrow: 5,2
        cyc("brw_start", 0, 1, 0, 8'd5, 8'd3, 8'd0, 1, 0, 0, 0, 8'd0);
        rq("brw_5", 0, 1, 1, 0, 8'd5);
        rq("brw_2", 0, 1, 1, 1, 8'd2);

        // Empty descending range: straight to DONE with value=min
        cyc("emp_start", 0, 1, 0, 8'd1, 8'd1, 8'd5, 1, 1, 0, 0, 8'd1);
        check("emp_state", 32'(st0), 32'(DONE));
        rq("emp_1", 0, 1, 1, 1, 8'd1);

        // step=0 and min==max give a single element
        cyc("s0_start", 0, 1, 0, 8'd6, 8'd0, 8'd20, 0, 0, 0, 0, 8'd0);
        rq("s0_6", 0, 1, 1, 1, 8'd6);
        cyc("eq_start", 0, 1, 0, 8'd5, 8'd1, 8'd5, 0, 0, 0, 0, 8'd0);
        rq("eq_5", 0, 1, 1, 1, 8'd5);

        // Gapped req, then restart mid-sequence with a simultaneous req
        cyc("gap_start", 0, 1, 0, 8'd3, 8'd2, 8'd9, 0, 0, 0, 0, 8'd0);
        rq("gap_3",    0, 1, 1, 0, 8'd3);
        rq("gap_hold", 0, 0, 0, 0, 8'd3);
        rq("gap_5",    0, 1, 1, 0, 8'd5);
        rq("gap_7",    0, 1, 1, 0, 8'd7);
        cyc("mid_start", 0, 1, 1, 8'd20, 8'd1, 8'd21, 0, 0, 0, 0, 8'd0);
`ifdef BOUNDED_ENUM_INDEX_EN
        check("idx_restart", 32'(bus0.index), 32'd0);
`endif
        rq("mid_20", 0, 1, 1, 0, 8'd20);
        rq("mid_21", 0, 1, 1, 1, 8'd21);

        // Async reset mid-RUN
        cyc("rr_start", 0, 1, 0, 8'd0, 8'd1, 8'd100, 0, 0, 0, 0, 8'd0);
        rq("rr_0", 0, 1, 1, 0, 8'd0);
        bus0.req = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("rr_ack",   32'(bus0.ack),   32'd0);
        check("rr_eol",   32'(bus0.eol),   32'd0);
        check("rr_value", 32'(bus0.value), 32'd0);
        check("rr_busy",  32'(bus0.busy),  32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        rq("rr_ign1", 0, 1, 0, 0, 8'd0);
        rq("rr_ign2", 0, 1, 0, 0, 8'd0);
        check("rr_state", 32'(st0), 32'(IDLE));

        // WRAP=1: 0,1,2,0,1,2,0
        cyc("wr_start", 1, 1, 0, 8'd0, 8'd1, 8'd2, 0, 0, 0, 0, 8'd0);
        rq("wr_0a", 1, 1, 1, 0, 8'd0);
        rq("wr_1a", 1, 1, 1, 0, 8'd1);
        rq("wr_2a", 1, 1, 1, 1, 8'd2);
        rq("wr_0b", 1, 1, 1, 0, 8'd0);
        rq("wr_gap", 1, 0, 0, 0, 8'd0);
        rq("wr_1b", 1, 1, 1, 0, 8'd1);
        rq("wr_2b", 1, 1, 1, 1, 8'd2);
        rq("wr_0c", 1, 1, 1, 0, 8'd0);

        // WRAP=1 single element repeats min with eol
        cyc("wr1_start", 1, 1, 0, 8'd7, 8'd0, 8'd9, 0, 0, 0, 0, 8'd0);
        rq("wr1_7a", 1, 1, 1, 1, 8'd7);
        rq("wr1_7b", 1, 1, 1, 1, 8'd7);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
